// File: rtl/mac_operand_streamer.sv
// Convolution front end: fetches a 4x4 image window and 4x4 filter, streams the 16
// byte pairs into the MAC, then hands the captured MAC result downstream.
`timescale 1ns/1ps
module mac_operand_streamer #(
  parameter int ADDR_W = 10,
  parameter int IMG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_data,
  output logic [3:0]        flt_addr,
  input  logic [7:0]        flt_data,
  output logic              mac_clear,
  output logic              mac_en,
  output logic [7:0]        mac_ai,
  output logic [7:0]        mac_bi,
  input  logic              mac_done,
  input  logic [7:0]        mac_out,
  output logic [7:0]        res,
  output logic              res_valid,
  input  logic              res_ready
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, WAIT, OUT} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        idx_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] img_addr_reg;
  logic [3:0]        flt_addr_reg;
  logic              mac_en_reg;
  logic [7:0]        res_reg;
  logic              res_valid_reg;

  logic              base_load, idx_clear, idx_step, res_capture, res_release;
  logic [3:0]        idx_inc;
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W-1:0] row_off [4];

  // Row offsets are elaboration-time constants; the sum wraps naturally at ADDR_W bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign row_off[gi] = ADDR_W'(gi * IMG_W);
  end

  assign idx_inc  = idx_reg + 4'd1;
  assign win_addr = base_reg + row_off[idx_inc[3:2]] + ADDR_W'(idx_inc[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    busy        = 1'b1;
    mac_clear   = 1'b0;
    base_load   = 1'b0;
    idx_clear   = 1'b0;
    idx_step    = 1'b0;
    res_capture = 1'b0;
    res_release = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          base_load  = 1'b1;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        mac_clear  = 1'b1;
        idx_clear  = 1'b1;
        state_next = FETCH;
      end
      FETCH: begin
        if (idx_reg == 4'd15) state_next = DRAIN;
        else                  idx_step   = 1'b1;
      end
      DRAIN: state_next = WAIT;
      WAIT: begin
        if (mac_done) begin
          res_capture = 1'b1;
          state_next  = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          res_release = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Addresses are registered one step ahead so FETCH idx n presents the address for n.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg       <= 4'd0;
      base_reg      <= '0;
      img_addr_reg  <= '0;
      flt_addr_reg  <= 4'd0;
      mac_en_reg    <= 1'b0;
      res_reg       <= 8'd0;
      res_valid_reg <= 1'b0;
    end else begin
      mac_en_reg <= (state_reg == FETCH);
      if (base_load) base_reg <= base_addr;
      if (idx_clear) begin
        idx_reg      <= 4'd0;
        img_addr_reg <= base_reg;
        flt_addr_reg <= 4'd0;
      end else if (idx_step) begin
        idx_reg      <= idx_inc;
        img_addr_reg <= win_addr;
        flt_addr_reg <= idx_inc;
      end
      if (res_capture) begin
        res_reg       <= mac_out;
        res_valid_reg <= 1'b1;
      end else if (res_release) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign img_addr  = img_addr_reg;
  assign flt_addr  = flt_addr_reg;
  assign mac_en    = mac_en_reg;
  assign mac_ai    = img_data;
  assign mac_bi    = flt_data;
  assign res       = res_reg;
  assign res_valid = res_valid_reg;

endmodule

// File: tb/tb_mac_operand_streamer.sv
// Directed and randomized windows for mac_operand_streamer, checked cycle by cycle
// against an arithmetic model of the window addressing and the MAC result.
`timescale 1ns/1ps
module tb_mac_operand_streamer;
  localparam int ADDR_W = 10;
  localparam int IMG_W  = 8;

  logic              clk = 1'b0;
  logic              rst, start, mac_done, res_ready;
  logic [ADDR_W-1:0] base_addr, img_addr;
  logic [3:0]        flt_addr;
  logic [7:0]        img_data, flt_data, mac_ai, mac_bi, mac_out, res;
  logic              busy, mac_clear, mac_en, res_valid;
  logic [7:0]        mac_acc;
  int                mac_cnt;
  int                tests = 0;
  int                fails = 0;

  always #5 clk = ~clk;

  mac_operand_streamer #(.ADDR_W(ADDR_W), .IMG_W(IMG_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy),
    .img_addr(img_addr), .img_data(img_data), .flt_addr(flt_addr), .flt_data(flt_data),
    .mac_clear(mac_clear), .mac_en(mac_en), .mac_ai(mac_ai), .mac_bi(mac_bi),
    .mac_done(mac_done), .mac_out(mac_out), .res(res), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  // Synchronous memories: image returns the low address byte, filter returns its index.
  always @(posedge clk) begin
    img_data <= img_addr[7:0];
    flt_data <= {4'h0, flt_addr};
  end

  // Simple MAC model accumulating whatever pairs the DUT presents.
  always @(posedge clk) begin
    if (mac_clear) begin
      mac_acc <= 8'd0;
      mac_cnt <= 0;
    end else if (mac_en) begin
      mac_acc <= mac_acc + 8'(mac_ai * mac_bi);
      mac_cnt <= mac_cnt + 1;
    end
  end

  function automatic logic [ADDR_W-1:0] ref_addr(input logic [ADDR_W-1:0] base, input int i);
    int a;
    a = int'(base) + (i / 4) * IMG_W + (i % 4);
    return ADDR_W'(a % (1 << ADDR_W));
  endfunction

  function automatic logic [7:0] ref_result(input logic [ADDR_W-1:0] base);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += (int'(ref_addr(base, i)) % 256) * i;
    return 8'(s % 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_clear"}, mac_clear, 0);
    chk({tag, "_en"}, mac_en, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_res"}, res, 0);
    chk({tag, "_img_addr"}, img_addr, 0);
    chk({tag, "_flt_addr"}, flt_addr, 0);
  endtask

  task automatic mid_reset();
    #1 rst = 1'b0;
    start = 1'b0;
    res_ready = 1'b0;
    #1 chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_rst_en", mac_en, 0);
      chk("post_rst_busy", busy, 0);
    end
  endtask

  task automatic run_window(input logic [ADDR_W-1:0] base, input int done_cyc, input int ready_wait,
                            input bit glitch, input bit early_ready, input int abort_at);
    logic [7:0] exp_res;
    logic [7:0] exp_ai;
    exp_res = ref_result(base);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    res_ready = early_ready;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start = glitch && (c == 5);
      base_addr = ADDR_W'($urandom);
      if (c == abort_at) begin
        mid_reset();
        return;
      end
      chk("fetch_busy", busy, 1);
      chk("mac_clear", mac_clear, (c == 1));
      chk("mac_en", mac_en, (c >= 3));
      if (c >= 2 && c <= 17) begin
        chk("img_addr", img_addr, ref_addr(base, c - 2));
        chk("flt_addr", flt_addr, c - 2);
      end
      if (c >= 3) begin
        exp_ai = 8'(ref_addr(base, c - 3));
        chk("mac_ai", mac_ai, exp_ai);
        chk("mac_bi", mac_bi, c - 3);
      end
    end
    for (int c = 19; c <= done_cyc; c++) begin
      @(negedge clk);
      start = glitch && (c == 20);
      chk("wait_busy", busy, 1);
      chk("wait_en", mac_en, 0);
      chk("wait_valid", res_valid, 0);
      mac_done = (c == done_cyc);
      mac_out = (c == done_cyc) ? mac_acc : 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    mac_done = 1'b0;
    mac_out = 8'($urandom);
    chk("mac_pair_count", mac_cnt, 16);
    for (int k = 0; k < ready_wait; k++) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_res", res, exp_res);
      @(negedge clk);
    end
    chk("out_valid", res_valid, 1);
    chk("out_res", res, exp_res);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("done_valid", res_valid, 0);
    chk("done_busy", busy, 0);
    chk("idle_res_hold", res, exp_res);
    $display("[TB] window base=%0h done_cyc=%0d ready_wait=%0d res=%0h expected=%0h",
             base, done_cyc, ready_wait, res, exp_res);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    base_addr = '0;
    mac_done = 1'b0;
    mac_out = 8'd0;
    res_ready = 1'b0;
    #2 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_window(10'h005, 25, 10, 1'b0, 1'b0, 0);
    run_window(10'h3FE, 19, 0, 1'b0, 1'b0, 0);
    run_window(ADDR_W'($urandom), 25, 3, 1'b1, 1'b0, 0);
    run_window(ADDR_W'($urandom), 22, 0, 1'b0, 1'b1, 0);
    run_window(10'h005, 25, 0, 1'b0, 1'b0, 10);
    run_window(10'h005, 21, 2, 1'b0, 1'b0, 0);
    for (int n = 0; n < 6; n++) begin
      run_window(ADDR_W'($urandom), 19 + int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 5)), 1'b0, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
